// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CH-channel arbitrating mux with one registered output stage.
// Each channel has a valid/ready handshake. One requester is granted per cycle,
// either round-robin from a rotating pointer or fixed priority (lowest index).
// The winner's data and index are registered. Flush drops the held beat and
// blocks accepts for that cycle.
module rr_arb_mux #(
   parameter int N    = 32,
   parameter int CH   = 4,
   parameter int MODE = 0,
   localparam int SW  = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [CH*N-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   output logic [N-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SW-1:0]     out_sel
);

   logic [SW-1:0] ptr_q, ptr_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_sel_q, out_sel_d;

   logic [SW-1:0] gnt_idx_s;
   logic          gnt_any_s;
   logic          slot_free_s;
   logic          accept_s;
   logic [CH-1:0] ready_s;
   logic [N-1:0]  gnt_data_s;
   int            idx_s;

   // Grant search: walk the search order backwards so the earliest match wins.
   always_comb begin
      gnt_any_s = 1'b0;
      gnt_idx_s = '0;
      idx_s     = 0;
      for (int k = CH - 1; k >= 0; k--) begin
         if (MODE == 0) begin
            idx_s = int'(ptr_q) + k;
            if (idx_s >= CH) begin
               idx_s = idx_s - CH;
            end else begin
               idx_s = idx_s;
            end
         end else begin
            idx_s = k;
         end
         if (in_valid[idx_s]) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = SW'(idx_s);
         end else begin
            gnt_any_s = gnt_any_s;
         end
      end
   end

   // Handshake: accept only when the output slot is free and no flush is pending.
   always_comb begin
      slot_free_s = ~out_valid_q | out_ready;
      accept_s    = gnt_any_s & slot_free_s & ~flush;
      ready_s     = '0;
      for (int i = 0; i < CH; i++) begin
         ready_s[i] = accept_s & (gnt_idx_s == SW'(i));
      end
   end

   // Data mux of the granted channel, decoded per channel to stay in range for any CH.
   always_comb begin
      gnt_data_s = '0;
      for (int i = 0; i < CH; i++) begin
         if (gnt_idx_s == SW'(i)) begin
            gnt_data_s = in_data[i*N +: N];
         end else begin
            gnt_data_s = gnt_data_s;
         end
      end
   end

   // Output stage and pointer next state: flush > accept > drain > hold.
   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data_s;
         out_sel_d   = gnt_idx_s;
         if (MODE == 0) begin
            if (gnt_idx_s == SW'(CH - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = gnt_idx_s + SW'(1);
            end
         end else begin
            ptr_d = '0;
         end
      end else if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers with immediate reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign in_ready  = ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (CH=4 round-robin, CH=4 fixed priority,
// CH=3 round-robin). Stimulus pushes expected beats into per-instance queues; a
// monitor pops and compares on every transferred beat.
module tb_rr_arb_mux;

   logic clk;
   logic rst;
   logic flush;

   logic [127:0] d4;
   logic [95:0]  d3;

   logic [3:0]  r_valid, r_in_ready;
   logic        r_ready, r_out_valid;
   logic [31:0] r_out_data;
   logic [1:0]  r_out_sel;

   logic [3:0]  f_valid, f_in_ready;
   logic        f_ready, f_out_valid;
   logic [31:0] f_out_data;
   logic [1:0]  f_out_sel;

   logic [2:0]  o_valid, o_in_ready;
   logic        o_ready, o_out_valid;
   logic [31:0] o_out_data;
   logic [1:0]  o_out_sel;

   logic [35:0] q_r[$];
   logic [35:0] q_f[$];
   logic [35:0] q_o[$];

   int n_cmp;
   int n_bad;

   rr_arb_mux #(.N(32), .CH(4), .MODE(0)) u_rr (
      .clk(clk), .rst(rst), .flush(flush), .in_data(d4), .in_valid(r_valid),
      .in_ready(r_in_ready), .out_data(r_out_data), .out_valid(r_out_valid),
      .out_ready(r_ready), .out_sel(r_out_sel));

   rr_arb_mux #(.N(32), .CH(4), .MODE(1)) u_fp (
      .clk(clk), .rst(rst), .flush(1'b0), .in_data(d4), .in_valid(f_valid),
      .in_ready(f_in_ready), .out_data(f_out_data), .out_valid(f_out_valid),
      .out_ready(f_ready), .out_sel(f_out_sel));

   rr_arb_mux #(.N(32), .CH(3), .MODE(0)) u_odd (
      .clk(clk), .rst(rst), .flush(1'b0), .in_data(d3), .in_valid(o_valid),
      .in_ready(o_in_ready), .out_data(o_out_data), .out_valid(o_out_valid),
      .out_ready(o_ready), .out_sel(o_out_sel));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] beat(input int ch, input logic [31:0] base);
      return {4'(ch), base + 32'(ch)};
   endfunction

   // Monitor: compare every beat the consumer actually takes.
   always @(negedge clk) begin
      logic [35:0] e;
      if (!rst && !flush && r_out_valid && r_ready) begin
         if (q_r.size() == 0) chk("rr_unexpected_beat", 64'(1), 64'(0));
         else begin
            e = q_r.pop_front();
            chk("rr_beat", 64'({2'b00, r_out_sel, r_out_data}), 64'(e));
         end
      end
      if (!rst && f_out_valid && f_ready) begin
         if (q_f.size() == 0) chk("fp_unexpected_beat", 64'(1), 64'(0));
         else begin
            e = q_f.pop_front();
            chk("fp_beat", 64'({2'b00, f_out_sel, f_out_data}), 64'(e));
         end
      end
      if (!rst && o_out_valid && o_ready) begin
         if (q_o.size() == 0) chk("odd_unexpected_beat", 64'(1), 64'(0));
         else begin
            e = q_o.pop_front();
            chk("odd_beat", 64'({2'b00, o_out_sel, o_out_data}), 64'(e));
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA0 + 32'(i);
      for (int i = 0; i < 3; i++) d3[i*32 +: 32] = 32'hC0 + 32'(i);
      rst = 1'b0; flush = 1'b0;
      r_valid = 4'h0; r_ready = 1'b0;
      f_valid = 4'h0; f_ready = 1'b0;
      o_valid = 3'h0; o_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset_rr_valid", 64'(r_out_valid), 64'(0));
      chk("reset_rr_data",  64'(r_out_data),  64'(0));
      chk("reset_rr_sel",   64'(r_out_sel),   64'(0));
      chk("reset_fp_valid", 64'(f_out_valid), 64'(0));
      chk("reset_odd_valid", 64'(o_out_valid), 64'(0));
      step();
      step();
      rst = 1'b0;

      // Round-robin, all channels valid
      r_valid = 4'hF; r_ready = 1'b1;
      #1 chk("rr_first_ready", 64'(r_in_ready), 64'(4'b0001));
      q_r.push_back(beat(0, 32'hA0)); q_r.push_back(beat(1, 32'hA0));
      q_r.push_back(beat(2, 32'hA0)); q_r.push_back(beat(3, 32'hA0));
      q_r.push_back(beat(0, 32'hA0)); q_r.push_back(beat(1, 32'hA0));
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_valid_every_cycle", 64'(r_out_valid), 64'(1));
         if (k == 5) r_valid = 4'h0;
      end
      step();
      chk("rr_drain", 64'(r_out_valid), 64'(0));

      // Backpressure: pointer now at 2
      r_ready = 1'b0; r_valid = 4'hF;
      q_r.push_back(beat(2, 32'hA0));
      step();
      for (int k = 0; k < 3; k++) begin
         chk("bp_in_ready", 64'(r_in_ready), 64'(0));
         chk("bp_sel_stable", 64'(r_out_sel), 64'(2));
         chk("bp_data_stable", 64'(r_out_data), 64'(32'hA2));
         if (k < 2) step();
      end
      r_ready = 1'b1;
      #1 chk("bp_release_ready", 64'(r_in_ready), 64'(4'b1000));
      q_r.push_back(beat(3, 32'hA0));
      step();
      chk("bp_no_bubble_valid", 64'(r_out_valid), 64'(1));
      chk("bp_no_bubble_sel", 64'(r_out_sel), 64'(3));
      r_valid = 4'h0;
      step();

      // Flush with a held beat and ch0 requesting
      r_valid = 4'b0001; r_ready = 1'b0;
      step();
      chk("fl_setup_valid", 64'(r_out_valid), 64'(1));
      flush = 1'b1; r_ready = 1'b1;
      #1 chk("fl_ready_blocked", 64'(r_in_ready), 64'(0));
      step();
      flush = 1'b0;
      chk("fl_dropped", 64'(r_out_valid), 64'(0));
      #1 chk("fl_next_ready", 64'(r_in_ready), 64'(4'b0001));
      q_r.push_back(beat(0, 32'hA0));
      step();
      chk("fl_beat_valid", 64'(r_out_valid), 64'(1));
      r_valid = 4'h0;
      step();

      // Asynchronous reset while a beat is held
      r_valid = 4'b0100; r_ready = 1'b0;
      step();
      r_valid = 4'h0;
      chk("rst_setup_sel", 64'(r_out_sel), 64'(2));
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(r_out_valid), 64'(0));
      chk("rst_async_data", 64'(r_out_data), 64'(0));
      chk("rst_async_sel", 64'(r_out_sel), 64'(0));
      step();
      rst = 1'b0; r_valid = 4'hF; r_ready = 1'b1;
      #1 chk("rst_ptr_zero", 64'(r_in_ready), 64'(4'b0001));
      q_r.push_back(beat(0, 32'hA0));
      step();
      r_valid = 4'h0;
      step();

      // Fixed priority
      f_valid = 4'b1010; f_ready = 1'b1;
      #1 chk("fp_ready_ch1", 64'(f_in_ready), 64'(4'b0010));
      for (int k = 0; k < 3; k++) q_f.push_back(beat(1, 32'hA0));
      for (int k = 0; k < 3; k++) begin
         step();
         if (k < 2) chk("fp_ready_ch1_again", 64'(f_in_ready), 64'(4'b0010));
      end
      f_valid = 4'b1000;
      #1 chk("fp_ready_ch3", 64'(f_in_ready), 64'(4'b1000));
      q_f.push_back(beat(3, 32'hA0));
      step();
      f_valid = 4'h0;
      step();

      // Odd channel count wrap
      o_valid = 3'b100; o_ready = 1'b1;
      #1 chk("odd_ready_ch2", 64'(o_in_ready), 64'(3'b100));
      q_o.push_back(beat(2, 32'hC0));
      step();
      o_valid = 3'b111;
      #1 chk("odd_wrap_grant", 64'(o_in_ready), 64'(3'b001));
      q_o.push_back(beat(0, 32'hC0)); q_o.push_back(beat(1, 32'hC0));
      q_o.push_back(beat(2, 32'hC0)); q_o.push_back(beat(0, 32'hC0));
      for (int k = 0; k < 4; k++) step();
      o_valid = 3'h0;
      step();

      step();
      step();
      chk("rr_queue_empty", 64'(q_r.size()), 64'(0));
      chk("fp_queue_empty", 64'(q_f.size()), 64'(0));
      chk("odd_queue_empty", 64'(q_o.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
